alu_exec_unit: RTL
==================

# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU decoder, together with two operands, through a valid/ready handshake. Returns the result, a zero flag and a branch-taken flag. Logic, arithmetic and compare operations complete in one cycle; shifts run iteratively at one bit per cycle, so the EX stage can stall on `in_ready`. It sits between the ID/EX pipeline register and the EX/MEM register.

## Interface

- `DATA_WIDTH`, 32: operand and result width.
- `SHAMT_WIDTH`, 5: shift-amount width, equal to log2(`DATA_WIDTH`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operation and operands are present.
- `in_ready` output 1: unit can accept; high only in IDLE.
- `Operation` input 4: ALU operation code, encoded as listed under Operation.
- `SrcA` input DATA_WIDTH: operand A (rs1 or PC).
- `SrcB` input DATA_WIDTH: operand B (rs2 or immediate).
- `out_valid` output 1: result registers hold a completed operation.
- `out_ready` input 1: downstream consumes the result.
- `ALUResult` output DATA_WIDTH: operation result.
- `Zero` output 1: high when `ALUResult` == 0.
- `BranchTaken` output 1: compare outcome; 0 for non-compare operations.
- `IllegalOp` output 1: the completed operation used code 1110 or 1111.

## Operation

- Codes:
  - 0000 AND
  - 0001 SUB
  - 0010 ADD (loads, stores, JALR)
  - 0011 OR
  - 0100 XOR
  - 0101 SRA
  - 0110 SLL
  - 0111 SLT (signed; result 1 or 0)
  - 1000 BEQ
  - 1001 SRL
  - 1010 BGE (signed)
  - 1011 BLT (signed)
  - 1100 BNE
  - 1101 LUI (result = SrcB)
  - 1110 and 1111 illegal
- Arithmetic is modulo 2^DATA_WIDTH; no overflow flag.
- Signed compares use two's complement.
- Compare codes (1000, 1010, 1011, 1100):
  - `ALUResult` = zero-extended condition bit.
  - `BranchTaken` = condition.
- Illegal codes: `ALUResult` = 0, `BranchTaken` = 0, `IllegalOp` = 1; handshake completes normally.
- Shifts:
  - Shift amount n = SrcB[SHAMT_WIDTH-1:0]; upper SrcB bits are ignored.
  - Working register is loaded with SrcA and shifted one position per cycle while a down-counter runs from n to 0.
  - SRA replicates the MSB; SRL and SLL fill with 0.
- State machine, with `in_ready` = (state == IDLE):
  - IDLE, on `in_valid`, shift op with n > 0: capture operands and operation, load counter, go to SHIFT.
  - IDLE, on `in_valid`, any other op, including a shift with n = 0: compute, register result, go to DONE.
  - SHIFT: shift once and decrement. When the counter reaches 1, the final shift is written to `ALUResult` and the state goes to DONE.
  - DONE: `out_valid` = 1. On `out_ready` go to IDLE; otherwise hold all outputs stable.
- Inputs are sampled only on the accept cycle (`in_valid` && `in_ready`). Changes to `Operation`/`SrcA`/`SrcB` during SHIFT or DONE have no effect.
- `Zero` is computed from the registered `ALUResult`.

## Timing

- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `ALUResult` = 0, `Zero` = 1, `BranchTaken` = 0, `IllegalOp` = 0, counter = 0.
- Latency from accept edge to `out_valid` high:
  - Non-shift op, or shift with n = 0: 1 cycle.
  - Shift with n > 0: n + 1 cycles (n SHIFT cycles plus the accept cycle).
- Handshake rules:
  - Result transfer occurs on the edge where `out_valid` && `out_ready`.
  - `in_ready` rises the cycle after transfer, so there is no accept in the transfer cycle.
  - Minimum initiation interval is 2 cycles.
- `out_ready` held high before `out_valid`: transfer happens on the first DONE cycle.
- Reset asserted mid-SHIFT or mid-DONE: immediately returns to reset values; the in-flight operation is discarded and no `out_valid` pulse follows.
- `in_valid` dropping while `in_ready` is low is legal and ignored.

## Test plan

- After reset, ADD with SrcA=0x0000_0005, SrcB=0xFFFF_FFFD (Operation=0010) -> after 1 cycle: `out_valid`=1, `ALUResult`=0x0000_0002, `Zero`=0.
- SRA with SrcA=0x8000_0000, SrcB=0x0000_0024 (shift amount 4) -> `in_ready` low for 4 cycles, `out_valid` at cycle 5, `ALUResult`=0xF800_0000.
- SLL with SrcB=0 and SrcA=0x1234_5678 -> 1-cycle latency, `ALUResult`=0x1234_5678. Then SRL by 31 of 0x8000_0000 -> `ALUResult`=0x0000_0001 after 32 cycles.
- Branch compares with SrcA=0xFFFF_FFFF, SrcB=0x0000_0001:
  - BLT -> `BranchTaken`=1, `ALUResult`=1.
  - BGE -> `BranchTaken`=0.
  - BEQ of equal operands -> `BranchTaken`=1.
  - BNE of equal operands -> `BranchTaken`=0.
- Hold `out_ready`=0 for 5 cycles in DONE while SrcA/Operation toggle randomly -> outputs stable, `in_ready`=0. Then release -> one transfer, and `in_ready`=1 on the next cycle. Issue Operation=1111 -> `IllegalOp`=1, `ALUResult`=0.
- Assert `rst_n` low during the third cycle of a 20-bit shift -> `out_valid` stays 0, `in_ready`=1 and `ALUResult`=0 immediately. A following ADD completes normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Logic, arithmetic and compare ops finish in one cycle; shifts run one bit per cycle.
module alu_exec_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  BranchTaken,
    output logic                  IllegalOp
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_BGE = 4'b1010;
    localparam logic [3:0] OP_BLT = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_LUI = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_work;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_branch;
    logic                    r_illegal;

    logic                    w_accept;
    logic                    w_is_shift;
    logic                    w_to_shift;
    logic [SHAMT_WIDTH-1:0]  w_shamt;
    logic                    w_lt;
    logic                    w_eq;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_branch;
    logic                    w_illegal;
    logic [DATA_WIDTH-1:0]   w_shifted;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_shamt    = SrcB[SHAMT_WIDTH-1:0];
    assign w_is_shift = (Operation == OP_SRA) || (Operation == OP_SLL) || (Operation == OP_SRL);
    assign w_to_shift = w_is_shift && (w_shamt != '0);
    assign w_lt       = $signed(SrcA) < $signed(SrcB);
    assign w_eq       = (SrcA == SrcB);

    // Single-cycle result; a shift by zero passes SrcA through unchanged.
    always_comb begin
        w_result  = '0;
        w_branch  = 1'b0;
        w_illegal = 1'b0;
        case (Operation)
            OP_AND: w_result = SrcA & SrcB;
            OP_SUB: w_result = SrcA - SrcB;
            OP_ADD: w_result = SrcA + SrcB;
            OP_OR:  w_result = SrcA | SrcB;
            OP_XOR: w_result = SrcA ^ SrcB;
            OP_SRA, OP_SLL, OP_SRL: w_result = SrcA;
            OP_SLT: w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            OP_BEQ: w_branch = w_eq;
            OP_BGE: w_branch = !w_lt;
            OP_BLT: w_branch = w_lt;
            OP_BNE: w_branch = !w_eq;
            OP_LUI: w_result = SrcB;
            default: w_illegal = 1'b1;
        endcase
        if ((Operation == OP_BEQ) || (Operation == OP_BGE) ||
            (Operation == OP_BLT) || (Operation == OP_BNE)) begin
            w_result = {{(DATA_WIDTH-1){1'b0}}, w_branch};
        end
    end

    always_comb begin
        w_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
        case (r_op)
            OP_SRA:  w_shifted = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
            OP_SLL:  w_shifted = {r_work[DATA_WIDTH-2:0], 1'b0};
            default: w_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_to_shift ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == SHAMT_WIDTH'(1)) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are captured only on accept; SHIFT works from the captured copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_branch  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_op      <= Operation;
            r_work    <= SrcA;
            r_branch  <= w_branch;
            r_illegal <= w_illegal;
            if (w_to_shift) r_cnt    <= w_shamt;
            else            r_result <= w_result;
        end else if (r_state == S_SHIFT) begin
            r_work <= w_shifted;
            r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
            if (r_cnt == SHAMT_WIDTH'(1)) r_result <= w_shifted;
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign ALUResult   = r_result;
    assign Zero        = (r_result == '0);
    assign BranchTaken = r_branch;
    assign IllegalOp   = r_illegal;

endmodule
